// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage data-cache access plus MEM/WB pipeline register
// Optional watchdog on stalled cache accesses: define MEM_WATCHDOG_EN.
module mem_wb_stage #(
  parameter int WATCHDOG_CYCLES = 256
) (
  input  logic        Clk,
  input  logic        rst_n,
  input  logic        Stall_ext,
  input  logic [31:0] ALUResult_MEM,
  input  logic [31:0] StoreData_MEM,
  input  logic [4:0]  WriteReg_Addr_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemToReg_MEM,
  input  logic        PCtoReg_MEM,
  input  logic [31:0] StorePC_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  output logic        DCACHE_ren,
  output logic        DCACHE_wen,
  output logic [29:0] DCACHE_addr,
  output logic [31:0] DCACHE_wdata,
  input  logic [31:0] DCACHE_rdata,
  input  logic        DCACHE_stall,
  output logic        Stall_MEM,
  output logic [31:0] Fwd_Data_MEM,
  output logic        RegWrite_WB,
  output logic [4:0]  WriteReg_Addr_WB,
  output logic [31:0] WriteReg_Data_WB,
  output logic        Mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HELD} state_t;

  state_t      state_q, state_d;
  logic [31:0] held_q, held_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        acc, ren, wen, stall_mem, wb_en;
  logic [31:0] load_data;

  assign acc          = MemRead_MEM | MemWrite_MEM;
  assign Fwd_Data_MEM = PCtoReg_MEM ? StorePC_MEM : ALUResult_MEM;
  assign DCACHE_addr  = ALUResult_MEM[31:2];
  assign DCACHE_wdata = StoreData_MEM;
  // Requests are gated by rst_n so an access in flight is dropped the moment reset asserts.
  assign DCACHE_ren   = rst_n & ren;
  assign DCACHE_wen   = rst_n & wen;
  assign Stall_MEM    = stall_mem;

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    ren       = 1'b0;
    wen       = 1'b0;
    stall_mem = 1'b0;
    case (state_q)
      S_IDLE: begin
        ren       = MemRead_MEM;
        wen       = MemWrite_MEM & ~MemRead_MEM;
        stall_mem = acc & DCACHE_stall;
        if (acc & DCACHE_stall) begin
          state_d = S_WAIT;
        end else if (acc & Stall_ext) begin
          held_d  = DCACHE_rdata;
          state_d = S_HELD;
        end
      end
      S_WAIT: begin
        ren       = MemRead_MEM;
        wen       = MemWrite_MEM & ~MemRead_MEM;
        stall_mem = acc & DCACHE_stall;
        if (!DCACHE_stall) begin
          if (Stall_ext) begin
            held_d  = DCACHE_rdata;
            state_d = S_HELD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HELD: begin
        if (!Stall_ext) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Any stall turns the WB slot into a bubble so each instruction writes once.
  always_comb begin
    wb_en      = ~stall_mem & ~Stall_ext;
    load_data  = (state_q == S_HELD) ? held_q : DCACHE_rdata;
    regwrite_d = wb_en ? RegWrite_MEM : 1'b0;
    wb_addr_d  = wb_en ? WriteReg_Addr_MEM : wb_addr_q;
    wb_data_d  = wb_data_q;
    if (wb_en) wb_data_d = MemToReg_MEM ? load_data : Fwd_Data_MEM;
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      held_q     <= '0;
      regwrite_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      regwrite_q <= regwrite_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign RegWrite_WB      = regwrite_q;
  assign WriteReg_Addr_WB = wb_addr_q;
  assign WriteReg_Data_WB = wb_data_q;

`ifdef MEM_WATCHDOG_EN
  localparam int CNT_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(WATCHDOG_CYCLES);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             mem_err_q, mem_err_d;

  // Counter saturates at the limit; the error is sticky and the access keeps going.
  always_comb begin
    wd_cnt_d  = '0;
    mem_err_d = mem_err_q;
    if (state_q == S_WAIT) begin
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
      if (wd_cnt_d == WD_MAX) mem_err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign Mem_err = mem_err_q;
`else
  logic wd_cfg_unused;
  assign wd_cfg_unused = |WATCHDOG_CYCLES;
  assign Mem_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
// Each instruction is modelled as one transaction: expected single writeback plus per-cycle request checks.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        Stall_ext;
  logic [31:0] ALUResult_MEM, StoreData_MEM, StorePC_MEM, DCACHE_rdata;
  logic [4:0]  WriteReg_Addr_MEM;
  logic        RegWrite_MEM, MemToReg_MEM, PCtoReg_MEM, MemRead_MEM, MemWrite_MEM;
  logic        DCACHE_ren, DCACHE_wen, DCACHE_stall, Stall_MEM;
  logic [29:0] DCACHE_addr;
  logic [31:0] DCACHE_wdata, Fwd_Data_MEM, WriteReg_Data_WB;
  logic        RegWrite_WB, Mem_err;
  logic [4:0]  WriteReg_Addr_WB;

  int n_chk  = 0;
  int n_fail = 0;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;

  mem_wb_stage #(.WATCHDOG_CYCLES(4)) dut (
    .Clk(Clk), .rst_n(rst_n), .Stall_ext(Stall_ext),
    .ALUResult_MEM(ALUResult_MEM), .StoreData_MEM(StoreData_MEM),
    .WriteReg_Addr_MEM(WriteReg_Addr_MEM), .RegWrite_MEM(RegWrite_MEM),
    .MemToReg_MEM(MemToReg_MEM), .PCtoReg_MEM(PCtoReg_MEM), .StorePC_MEM(StorePC_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .DCACHE_ren(DCACHE_ren), .DCACHE_wen(DCACHE_wen), .DCACHE_addr(DCACHE_addr),
    .DCACHE_wdata(DCACHE_wdata), .DCACHE_rdata(DCACHE_rdata), .DCACHE_stall(DCACHE_stall),
    .Stall_MEM(Stall_MEM), .Fwd_Data_MEM(Fwd_Data_MEM), .RegWrite_WB(RegWrite_WB),
    .WriteReg_Addr_WB(WriteReg_Addr_WB), .WriteReg_Data_WB(WriteReg_Data_WB), .Mem_err(Mem_err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bubble_chk(input string tag);
    chk({tag, "_bubble_we"}, {31'd0, RegWrite_WB}, 32'd0);
    chk({tag, "_hold_addr"}, {27'd0, WriteReg_Addr_WB}, {27'd0, prev_addr});
    chk({tag, "_hold_data"}, WriteReg_Data_WB, prev_data);
  endtask

  // One instruction: miss = cache-busy cycles, ext = cycles Stall_ext stays high once the cache is done.
  task automatic run_instr(input string tag, input logic rd, input logic wr, input logic rw,
                           input logic p2r, input logic [4:0] dst, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [31:0] pc, input logic [31:0] ld,
                           input int miss_in, input int ext);
    logic [31:0] exp_fwd, exp_data;
    logic        exp_ren, exp_wen;
    int          miss;
    miss     = (rd | wr) ? miss_in : 0;
    exp_fwd  = p2r ? pc : alu;
    exp_data = rd ? ld : exp_fwd;
    exp_ren  = rd;
    exp_wen  = wr & ~rd;
    @(negedge Clk);
    MemRead_MEM = rd; MemWrite_MEM = wr; RegWrite_MEM = rw; MemToReg_MEM = rd;
    PCtoReg_MEM = p2r; WriteReg_Addr_MEM = dst; ALUResult_MEM = alu;
    StoreData_MEM = sd; StorePC_MEM = pc;
    for (int i = 0; i < miss; i++) begin
      DCACHE_stall = 1'b1; Stall_ext = 1'($urandom_range(0, 1)); DCACHE_rdata = $urandom;
      #1;
      chk({tag, "_miss_stall"}, {31'd0, Stall_MEM}, 32'd1);
      chk({tag, "_miss_ren"}, {31'd0, DCACHE_ren}, {31'd0, exp_ren});
      chk({tag, "_miss_wen"}, {31'd0, DCACHE_wen}, {31'd0, exp_wen});
      chk({tag, "_miss_addr"}, {2'd0, DCACHE_addr}, {2'd0, alu[31:2]});
      @(posedge Clk); #1;
      bubble_chk({tag, "_miss"});
      @(negedge Clk);
    end
    DCACHE_stall = 1'b0; DCACHE_rdata = ld; Stall_ext = (ext > 0);
    #1;
    chk({tag, "_done_stall"}, {31'd0, Stall_MEM}, 32'd0);
    chk({tag, "_ren"}, {31'd0, DCACHE_ren}, {31'd0, exp_ren});
    chk({tag, "_wen"}, {31'd0, DCACHE_wen}, {31'd0, exp_wen});
    chk({tag, "_addr"}, {2'd0, DCACHE_addr}, {2'd0, alu[31:2]});
    chk({tag, "_wdata"}, DCACHE_wdata, sd);
    chk({tag, "_fwd"}, Fwd_Data_MEM, exp_fwd);
    @(posedge Clk); #1;
    if (ext > 0) begin
      bubble_chk({tag, "_ext"});
      for (int j = 1; j <= ext; j++) begin
        @(negedge Clk);
        Stall_ext = (j < ext); DCACHE_stall = 1'($urandom_range(0, 1)); DCACHE_rdata = $urandom;
        #1;
        chk({tag, "_held_ren"}, {31'd0, DCACHE_ren}, 32'd0);
        chk({tag, "_held_wen"}, {31'd0, DCACHE_wen}, 32'd0);
        chk({tag, "_held_stall"}, {31'd0, Stall_MEM}, 32'd0);
        @(posedge Clk); #1;
        if (j < ext) bubble_chk({tag, "_held"});
      end
    end
    chk({tag, "_wb_we"}, {31'd0, RegWrite_WB}, {31'd0, rw});
    chk({tag, "_wb_addr"}, {27'd0, WriteReg_Addr_WB}, {27'd0, dst});
    chk({tag, "_wb_data"}, WriteReg_Data_WB, exp_data);
    prev_addr = dst;
    prev_data = exp_data;
  endtask

  initial begin
    rst_n = 1'b0; Stall_ext = 1'b0; ALUResult_MEM = '0; StoreData_MEM = '0; StorePC_MEM = '0;
    DCACHE_rdata = '0; WriteReg_Addr_MEM = '0; RegWrite_MEM = 1'b0; MemToReg_MEM = 1'b0;
    PCtoReg_MEM = 1'b0; MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; DCACHE_stall = 1'b0;
    prev_addr = '0; prev_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_we", {31'd0, RegWrite_WB}, 32'd0);
    chk("rst_addr", {27'd0, WriteReg_Addr_WB}, 32'd0);
    chk("rst_data", WriteReg_Data_WB, 32'd0);
    chk("rst_err", {31'd0, Mem_err}, 32'd0);
    @(negedge Clk);
    rst_n = 1'b1;

    run_instr("load_hit", 1, 0, 1, 0, 5'd8, 32'h0000_0040, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_instr("load_miss", 1, 0, 1, 0, 5'd9, 32'h0000_1234, 32'h0, 32'h0, 32'hCAFE_F00D, 5, 0);
    run_instr("store_miss_ext", 0, 1, 0, 0, 5'd3, 32'h0000_0200, 32'h1357_9BDF, 32'h0, 32'h0, 2, 3);
    run_instr("jal", 0, 0, 1, 1, 5'd31, 32'h0000_0ABC, 32'h0, 32'h0000_0108, 32'h0, 0, 0);
    run_instr("ld_st_both", 1, 1, 1, 0, 5'd4, 32'h0000_0080, 32'hFFFF_0000, 32'h0, 32'h1111_2222, 1, 0);
    run_instr("load_hit_ext", 1, 0, 1, 0, 5'd0, 32'h0000_0044, 32'h0, 32'h0, 32'h5555_AAAA, 0, 2);

    // Reset while waiting on a miss
    @(negedge Clk);
    MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; RegWrite_MEM = 1'b1; MemToReg_MEM = 1'b1;
    PCtoReg_MEM = 1'b0; WriteReg_Addr_MEM = 5'd7; ALUResult_MEM = 32'h0000_0100;
    DCACHE_stall = 1'b1; Stall_ext = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ren", {31'd0, DCACHE_ren}, 32'd0);
    chk("rst_wait_wen", {31'd0, DCACHE_wen}, 32'd0);
    chk("rst_wait_we", {31'd0, RegWrite_WB}, 32'd0);
    chk("rst_wait_data", WriteReg_Data_WB, 32'd0);
    @(negedge Clk);
    rst_n = 1'b1; DCACHE_stall = 1'b0;
    prev_addr = '0; prev_data = '0;
    run_instr("after_rst", 1, 0, 1, 0, 5'd7, 32'h0000_0100, 32'h0, 32'h0, 32'h0BAD_CAFE, 0, 0);

`ifdef MEM_WATCHDOG_EN
    @(negedge Clk);
    MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; RegWrite_MEM = 1'b1; MemToReg_MEM = 1'b1;
    PCtoReg_MEM = 1'b0; WriteReg_Addr_MEM = 5'd12; ALUResult_MEM = 32'h0000_0300;
    Stall_ext = 1'b0; DCACHE_stall = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge Clk); #1;
      chk("wd_err", {31'd0, Mem_err}, {31'd0, (k >= 5)});
    end
    @(negedge Clk);
    DCACHE_stall = 1'b0; DCACHE_rdata = 32'h7777_0001;
    @(posedge Clk); #1;
    chk("wd_err_sticky", {31'd0, Mem_err}, 32'd1);
    chk("wd_wb_data", WriteReg_Data_WB, 32'h7777_0001);
    prev_addr = 5'd12; prev_data = 32'h7777_0001;
`endif

    for (int n = 0; n < 40; n++) begin
      int          kind;
      logic        rd, wr, rw, p2r;
      kind = $urandom_range(0, 4);
      rd   = (kind == 1) || (kind == 4);
      wr   = (kind == 2) || (kind == 4);
      p2r  = (kind == 3);
      rw   = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      run_instr("rand", rd, wr, rw, p2r, 5'($urandom), $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

`ifndef MEM_WATCHDOG_EN
    chk("err_off", {31'd0, Mem_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
